nios_debug_ocimem_engine: RTL and testbench
===========================================

Name: nios_debug_ocimem_engine

Overview:
- Downstream consumer of the debug-slave sysclk strobes (`jdo`, `take_action_ocimem_a/b`, `take_no_action_ocimem_a`).
- Owns the CPU's on-chip debug monitor RAM and executes JTAG-side address-load, write and auto-increment-read commands against it.
- Returns read data as `MonDReg`, which feeds back into the debug slave's TCK scan chain.
- Also exposes an Avalon-MM slave so the CPU (in debug mode) reaches the same RAM. JTAG side has absolute priority.

Parameters:
- ADDR_W, 8, word-address width; RAM depth = 2^ADDR_W words of 32 bits.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- jdo  in  38  JTAG data word from debug slave sysclk stage
- take_action_ocimem_a  in  1  one-cycle strobe: load address (optional read)
- take_action_ocimem_b  in  1  one-cycle strobe: write word, post-increment
- take_no_action_ocimem_a  in  1  one-cycle strobe: increment address then read
- address  in  ADDR_W  Avalon word address
- chipselect  in  1  Avalon select
- read  in  1  Avalon read
- write  in  1  Avalon write
- writedata  in  32  Avalon write data
- byteenable  in  4  Avalon byte enables
- debugaccess  in  1  Avalon write permission qualifier
- readdata  out  32  Avalon read data
- waitrequest  out  1  Avalon stall
- MonDReg  out  32  last JTAG read data
- MonAReg  out  ADDR_W  current JTAG word address
- mon_rd_valid  out  1  one-cycle pulse when MonDReg updated

Behaviour:
- Reset (async, any time):
  - MonAReg=0, MonDReg=0, readdata=0, waitrequest=1, mon_rd_valid=0, Avalon FSM=IDLE.
  - In-flight accesses are dropped. RAM contents are not reset.
- RAM: single port, synchronous. Address/data/we presented in cycle T; read data valid in T+1.
- JTAG strobe priority if several are high in one cycle: take_action_ocimem_a > take_action_ocimem_b > take_no_action_ocimem_a. Lower strobes are ignored.
- take_action_ocimem_a:
  - MonAReg <= jdo[26+ADDR_W-1:26].
  - If jdo[17]=1, issue a RAM read at that address in the same cycle.
- take_action_ocimem_b:
  - RAM write of jdo[34:3] to MonAReg, all bytes.
  - MonAReg <= MonAReg+1.
- take_no_action_ocimem_a:
  - MonAReg <= MonAReg+1.
  - RAM read issued at MonAReg+1 in the same cycle.
- JTAG read completion: MonDReg <= RAM q at the end of T+1; mon_rd_valid=1 in T+2 for exactly one cycle. Latency is 2 cycles from strobe to valid.
- Address arithmetic: modulo 2^ADDR_W. All-ones + 1 wraps to 0, no flag.
- Avalon FSM states: IDLE, RD_WAIT, ACK.
  - IDLE:
    - Needs chipselect & (read|write) and no JTAG strobe this cycle.
    - Read: issue RAM read at `address`, go to RD_WAIT.
    - Write: if debugaccess=1, write writedata with byteenable; if debugaccess=0, discard the write. Either way go to ACK.
    - read & write together is treated as read.
    - If a JTAG strobe is present, stay in IDLE (stall).
  - RD_WAIT: readdata <= RAM q, go to ACK. A JTAG strobe here may use the RAM port; no corruption.
  - ACK: waitrequest=0 for exactly one cycle, then IDLE.
- waitrequest: 1 in every state except ACK. Read completes in 3 cycles, write in 2, if not stalled.
- readdata holds its value until the next Avalon read completes.
- Same-address hazard: JTAG write in T with Avalon read issued T+1 returns the new data. The RAM is read-after-write across cycles.

Test Plan:
- Reset mid Avalon read (in RD_WAIT): assert reset -> waitrequest=1, readdata=0, FSM IDLE; next read of addr 5 completes normally in 3 cycles.
- take_action_ocimem_a with jdo addr field=0x10, jdo[17]=0; then take_action_ocimem_b ×2 with data 0xDEADBEEF, 0x12345678 -> MonAReg=0x12; Avalon reads of 0x10 and 0x11 return those words.
- take_action_ocimem_a addr=0x10 with jdo[17]=1 -> MonDReg=0xDEADBEEF, mon_rd_valid pulses at T+2; take_no_action_ocimem_a -> MonAReg=0x11, MonDReg=0x12345678.
- MonAReg=0xFF, take_no_action_ocimem_a -> MonAReg=0x00, read returns word 0; take_action_ocimem_b at 0xFF -> MonAReg=0x00.
- Avalon write 0xAABBCCDD to addr 3: byteenable=4'b0011 with debugaccess=1 -> readback 0x????CCDD (old upper bytes kept); with debugaccess=0 -> RAM unchanged, waitrequest still drops after 2 cycles.
- Avalon read pending in IDLE while JTAG strobes arrive on 3 consecutive cycles -> Avalon stalled 3 cycles, then completes with correct data; all JTAG ops correct; a and b strobes asserted together -> only a acts.

Source files
------------

// File: rtl/nios_debug_ocimem_engine.sv
// On-chip debug monitor RAM with JTAG command engine (address load, write,
// auto-increment read) and an Avalon-MM slave port; JTAG always wins the RAM.
module nios_debug_ocimem_engine #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    input  logic              debugaccess,
    output logic [31:0]       readdata,
    output logic              waitrequest,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              mon_rd_valid
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        ACK
    } av_state_t;

    localparam int DEPTH = 1 << ADDR_W;

    av_state_t         state_q, state_d;
    logic [ADDR_W-1:0] mon_areg_d;
    logic              jtag_rd, jtag_rd_q;
    logic              any_strobe;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       ram_q;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_be;
    logic              ram_we;
    logic              ram_rd;

    logic [ADDR_W-1:0] jtag_addr;
    logic [ADDR_W-1:0] areg_inc;

    // Only the address field, read flag and data field of jdo are meaningful here.
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    assign jtag_addr   = jdo[26 +: ADDR_W];
    assign areg_inc    = MonAReg + ADDR_W'(1);
    assign any_strobe  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign waitrequest = (state_q != ACK);

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        mon_areg_d = MonAReg;
        jtag_rd    = 1'b0;
        ram_rd     = 1'b0;
        ram_we     = 1'b0;
        ram_be     = 4'h0;
        ram_addr   = MonAReg;
        ram_wdata  = jdo[34:3];

        if (take_action_ocimem_a) begin
            mon_areg_d = jtag_addr;
            ram_addr   = jtag_addr;
            if (jdo[17]) begin
                ram_rd  = 1'b1;
                jtag_rd = 1'b1;
            end
        end else if (take_action_ocimem_b) begin
            ram_we     = 1'b1;
            ram_be     = 4'hF;
            mon_areg_d = areg_inc;
        end else if (take_no_action_ocimem_a) begin
            mon_areg_d = areg_inc;
            ram_addr   = areg_inc;
            ram_rd     = 1'b1;
            jtag_rd    = 1'b1;
        end

        // The Avalon side touches the RAM only from IDLE and only when JTAG is quiet.
        case (state_q)
            IDLE: begin
                if (!any_strobe && chipselect && (read || write)) begin
                    if (read) begin
                        ram_rd   = 1'b1;
                        ram_addr = address;
                        state_d  = RD_WAIT;
                    end else begin
                        if (debugaccess) begin
                            ram_we    = 1'b1;
                            ram_be    = byteenable;
                            ram_addr  = address;
                            ram_wdata = writedata;
                        end
                        state_d = ACK;
                    end
                end
            end
            RD_WAIT: state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the RAM array and its output register carry no reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
        if (ram_rd) ram_q <= mem[ram_addr];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            MonAReg      <= '0;
            MonDReg      <= '0;
            readdata     <= '0;
            jtag_rd_q    <= 1'b0;
            mon_rd_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            MonAReg      <= mon_areg_d;
            jtag_rd_q    <= jtag_rd;
            mon_rd_valid <= jtag_rd_q;
            if (jtag_rd_q) MonDReg <= ram_q;
            if (state_q == RD_WAIT) readdata <= ram_q;
        end
    end

endmodule

// File: tb/tb_nios_debug_ocimem_engine.sv
// Randomized self-checking bench for nios_debug_ocimem_engine against an
// array-based model of the monitor RAM and JTAG address register.
module tb_nios_debug_ocimem_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [7:0]  address;
    logic        chipselect, read, write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        debugaccess;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [31:0] MonDReg;
    logic [7:0]  MonAReg;
    logic        mon_rd_valid;

    nios_debug_ocimem_engine #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .address                 (address),
        .chipselect              (chipselect),
        .read                    (read),
        .write                   (write),
        .writedata               (writedata),
        .byteenable              (byteenable),
        .debugaccess             (debugaccess),
        .readdata                (readdata),
        .waitrequest             (waitrequest),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .mon_rd_valid            (mon_rd_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem_m [256];
    logic [7:0]  m_areg;
    logic [31:0] m_dreg;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [37:0] jdo_addr(input logic [7:0] a, input logic rd);
        logic [37:0] j;
        j = '0;
        j[33:26] = a;
        j[17] = rd;
        return j;
    endfunction

    function automatic logic [37:0] jdo_data(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    // One JTAG command from cycle T; checks MonAReg in T+1, read result/pulse in T+2, pulse gone in T+3.
    task automatic jtag(input logic sa, input logic sb, input logic sn, input logic [37:0] j);
        logic        rd;
        logic [31:0] exp;
        rd  = 1'b0;
        exp = m_dreg;
        if (sa) begin
            m_areg = j[33:26];
            if (j[17]) begin
                rd  = 1'b1;
                exp = mem_m[m_areg];
            end
        end else if (sb) begin
            mem_m[m_areg] = j[34:3];
            m_areg = m_areg + 8'd1;
        end else if (sn) begin
            m_areg = m_areg + 8'd1;
            rd  = 1'b1;
            exp = mem_m[m_areg];
        end
        if (rd) m_dreg = exp;

        take_action_ocimem_a    = sa;
        take_action_ocimem_b    = sb;
        take_no_action_ocimem_a = sn;
        jdo = j;
        @(posedge clk); #1;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        check("jtag_areg", MonAReg, m_areg);
        check("jtag_valid_t1", mon_rd_valid, 1'b0);
        @(posedge clk); #1;
        check("jtag_valid_t2", mon_rd_valid, rd);
        check("jtag_dreg", MonDReg, m_dreg);
        @(posedge clk); #1;
        check("jtag_valid_t3", mon_rd_valid, 1'b0);
    endtask

    // Avalon transfer started at #1 after a rising edge; returns the cycle count to waitrequest low.
    task automatic av_xfer(input logic rd, input logic wr, input logic [7:0] a,
                           input logic [31:0] wd, input logic [3:0] be, input logic dbg,
                           output int lat, output logic [31:0] rdata);
        chipselect  = 1'b1;
        read        = rd;
        write       = wr;
        address     = a;
        writedata   = wd;
        byteenable  = be;
        debugaccess = dbg;
        lat   = 0;
        rdata = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (!waitrequest) begin
                lat = c;
                break;
            end
        end
        rdata = readdata;
        @(posedge clk); #1;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        if (lat == 0) check("av_timeout", 64'd0, 64'd1);
    endtask

    task automatic av_read(input string tag, input logic [7:0] a, input int exp_lat);
        int          lat;
        logic [31:0] d;
        av_xfer(1'b1, 1'b0, a, 32'h0, 4'h0, 1'b0, lat, d);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_data"}, d, mem_m[a]);
    endtask

    task automatic av_write(input string tag, input logic [7:0] a, input logic [31:0] wd,
                            input logic [3:0] be, input logic dbg);
        int          lat;
        logic [31:0] d;
        if (dbg) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem_m[a][8*i +: 8] = wd[8*i +: 8];
        end
        av_xfer(1'b0, 1'b1, a, wd, be, dbg, lat, d);
        check({tag, "_lat"}, lat, 2);
    endtask

    initial begin
        int          lat;
        logic [31:0] d;
        logic [31:0] old3;

        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        writedata = '0; byteenable = '0; debugaccess = 1'b0;
        m_areg = '0;
        m_dreg = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_waitrequest", waitrequest, 1'b1);
        check("rst_readdata", readdata, 32'h0);
        check("rst_areg", MonAReg, 8'h0);
        check("rst_dreg", MonDReg, 32'h0);
        check("rst_valid", mon_rd_valid, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Fill every word through JTAG; the last write wraps MonAReg from 0xFF to 0.
        jtag(1'b1, 1'b0, 1'b0, jdo_addr(8'h00, 1'b0));
        for (int i = 0; i < 256; i++) jtag(1'b0, 1'b1, 1'b0, jdo_data($urandom()));
        check("fill_wrap_areg", MonAReg, 8'h00);

        // Directed JTAG load/write/read sequence.
        jtag(1'b1, 1'b0, 1'b0, jdo_addr(8'h10, 1'b0));
        jtag(1'b0, 1'b1, 1'b0, jdo_data(32'hDEADBEEF));
        jtag(1'b0, 1'b1, 1'b0, jdo_data(32'h12345678));
        check("dir_areg_12", MonAReg, 8'h12);
        av_read("dir_rd10", 8'h10, 3);
        check("dir_rd10_const", mem_m[8'h10], 32'hDEADBEEF);
        av_read("dir_rd11", 8'h11, 3);
        jtag(1'b1, 1'b0, 1'b0, jdo_addr(8'h10, 1'b1));
        check("dir_dreg_beef", MonDReg, 32'hDEADBEEF);
        jtag(1'b0, 1'b0, 1'b1, 38'h0);
        check("dir_dreg_5678", MonDReg, 32'h12345678);

        // Address wrap on increment-read and on write.
        jtag(1'b1, 1'b0, 1'b0, jdo_addr(8'hFF, 1'b0));
        jtag(1'b0, 1'b0, 1'b1, 38'h0);
        check("wrap_rd_areg", MonAReg, 8'h00);
        jtag(1'b1, 1'b0, 1'b0, jdo_addr(8'hFF, 1'b0));
        jtag(1'b0, 1'b1, 1'b0, jdo_data(32'hCAFEF00D));
        check("wrap_wr_areg", MonAReg, 8'h00);
        av_read("wrap_rd_ff", 8'hFF, 3);

        // Byte-enabled write with and without debugaccess.
        old3 = mem_m[3];
        av_write("be_wr", 8'h03, 32'hAABBCCDD, 4'b0011, 1'b1);
        av_read("be_rd", 8'h03, 3);
        check("be_rd_const", mem_m[3], {old3[31:16], 16'hCCDD});
        av_write("nodbg_wr", 8'h03, 32'h11111111, 4'b1111, 1'b0);
        av_read("nodbg_rd", 8'h03, 3);

        // Both a and b strobes together: only the address load acts.
        jtag(1'b1, 1'b1, 1'b0, jdo_addr(8'h40, 1'b1));
        av_read("ab_rd40", 8'h40, 3);

        // Avalon read stalled by three consecutive JTAG strobes.
        mem_m[8'h20] = 32'h0BAD0001;
        mem_m[8'h21] = 32'h0BAD0002;
        m_areg = 8'h22;
        fork
            av_xfer(1'b1, 1'b0, 8'h20, 32'h0, 4'h0, 1'b0, lat, d);
            begin
                take_action_ocimem_a = 1'b1;
                jdo = jdo_addr(8'h20, 1'b0);
                @(posedge clk); #1;
                take_action_ocimem_a = 1'b0;
                take_action_ocimem_b = 1'b1;
                jdo = jdo_data(32'h0BAD0001);
                @(posedge clk); #1;
                jdo = jdo_data(32'h0BAD0002);
                @(posedge clk); #1;
                take_action_ocimem_b = 1'b0;
            end
        join
        check("stall_lat", lat, 6);
        check("stall_data", d, 32'h0BAD0001);
        check("stall_areg", MonAReg, m_areg);
        av_read("stall_rd21", 8'h21, 3);

        // Reset while an Avalon read sits in RD_WAIT.
        chipselect = 1'b1; read = 1'b1; address = 8'h10;
        @(posedge clk); #1;
        check("mid_waitrequest", waitrequest, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_waitrequest", waitrequest, 1'b1);
        check("mid_rst_readdata", readdata, 32'h0);
        check("mid_rst_areg", MonAReg, 8'h0);
        check("mid_rst_dreg", MonDReg, 32'h0);
        chipselect = 1'b0; read = 1'b0;
        m_areg = '0;
        m_dreg = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        av_read("post_rst_rd5", 8'h05, 3);

        // Randomized mix of JTAG commands and Avalon transfers.
        for (int n = 0; n < 200; n++) begin
            int op;
            op = int'($urandom_range(4));
            if (op < 3) begin
                logic [2:0] s;
                s = 3'($urandom_range(1, 7));
                jtag(s[0], s[1], s[2], 38'({$urandom(), $urandom()}));
            end else if (op == 3) begin
                av_read("rnd_rd", 8'($urandom_range(255)), 3);
            end else begin
                av_write("rnd_wr", 8'($urandom_range(255)), $urandom(),
                         4'($urandom_range(15)), 1'($urandom_range(1)));
            end
        end
        for (int a = 0; a < 8; a++) av_read("final_rd", 8'(a * 37), 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
